vpu_sram_port_model: RTL and testbench

- Parametrised, cycle-accurate SRAM responder that replaces the fixed single-source read/write response tasks on the VPU source and destination port interfaces.
- Serves NUM_RD_PORTS independent read channels and one write channel from a shared backing store.
- Configurable read latency, LFSR-driven backpressure and per-channel traffic counters.
- Sits beside VPU_TOP in the top-level bench: src port reads and dst port writes terminate here.

---
 rtl/vpu_sram_port_model.sv | 133 +++++++++++++
 tb/tb_vpu_sram_port_model.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_sram_port_model.sv
// Cycle-accurate SRAM responder for the VPU src/dst port interfaces: NUM_RD_PORTS read
// channels and one write channel share one backing store, with fixed read latency and optional LFSR stalls.
module vpu_sram_port_model #(
    parameter int          NUM_RD_PORTS = 3,
    parameter int          ADDR_W       = 16,
    parameter int          DATA_W       = 256,
    parameter int          MEM_DEPTH    = 1024,
    parameter int          RD_LATENCY   = 2,
    parameter int          STALL_EN     = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_RD_PORTS-1:0]          rd_req_valid,
    output logic [NUM_RD_PORTS-1:0]          rd_req_ready,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0]   rd_req_addr,
    output logic [NUM_RD_PORTS-1:0]          rd_rsp_valid,
    output logic [NUM_RD_PORTS*DATA_W-1:0]   rd_rsp_data,
    input  logic                             wr_req_valid,
    output logic                             wr_req_ready,
    input  logic [ADDR_W-1:0]                wr_req_addr,
    input  logic [DATA_W-1:0]                wr_req_data,
    output logic                             wr_done,
    output logic [NUM_RD_PORTS*32-1:0]       rd_cnt,
    output logic [31:0]                      wr_cnt,
    output logic                             addr_err
);

    localparam int              IDX_W   = $clog2(MEM_DEPTH);
    localparam int              REP     = DATA_W / ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

    logic [15:0]              lfsr;
    logic [DATA_W-1:0]        mem [MEM_DEPTH];
    logic [MEM_DEPTH-1:0]     written;

    logic [NUM_RD_PORTS-1:0]  rd_acc;
    logic [NUM_RD_PORTS-1:0]  rd_oor;
    logic [IDX_W-1:0]         rd_idx [NUM_RD_PORTS];
    logic [DATA_W-1:0]        rd_cap [NUM_RD_PORTS];
    logic                     wr_acc;
    logic                     wr_oor;
    logic [IDX_W-1:0]         wr_idx;

    logic [RD_LATENCY-1:0]    pipe_v [NUM_RD_PORTS];
    logic [DATA_W-1:0]        pipe_d [NUM_RD_PORTS][RD_LATENCY];
    logic [31:0]              rd_cnt_q [NUM_RD_PORTS];

    // Handshake: a transfer happens on the rising edge where valid & ready are both high.
    // Ready is a function of the LFSR state only, so there is no valid->ready path; the
    // requester holds valid/addr/data stable until accepted. Read responses have no backpressure.
    always_comb begin
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            rd_req_ready[i] = (STALL_EN != 0) ? ~lfsr[i] : 1'b1;
        end
        wr_req_ready = (STALL_EN != 0) ? ~lfsr[15] : 1'b1;
    end

    assign rd_acc = rd_req_valid & rd_req_ready;
    assign wr_acc = wr_req_valid & wr_req_ready;
    assign wr_idx = wr_req_addr[IDX_W-1:0];
    assign wr_oor = {1'b0, wr_req_addr} >= DEPTH_L;

    // Capture uses the pre-edge array, which gives read-before-write on a same-edge collision.
    always_comb begin
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            rd_idx[i] = rd_req_addr[i*ADDR_W +: IDX_W];
            rd_oor[i] = {1'b0, rd_req_addr[i*ADDR_W +: ADDR_W]} >= DEPTH_L;
            rd_cap[i] = written[rd_idx[i]] ? mem[rd_idx[i]]
                                           : {REP{rd_req_addr[i*ADDR_W +: ADDR_W]}};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_idx] <= wr_req_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr     <= LFSR_SEED;
            written  <= '0;
            wr_done  <= 1'b0;
            wr_cnt   <= '0;
            addr_err <= 1'b0;
            for (int i = 0; i < NUM_RD_PORTS; i++) begin
                pipe_v[i]   <= '0;
                rd_cnt_q[i] <= '0;
                for (int s = 0; s < RD_LATENCY; s++) begin
                    pipe_d[i][s] <= '0;
                end
            end
        end else begin
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            wr_done <= wr_acc;
            if (wr_acc) begin
                written[wr_idx] <= 1'b1;
            end
            if (wr_acc && wr_cnt != 32'hFFFF_FFFF) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
            if ((wr_acc && wr_oor) || |(rd_acc & rd_oor)) begin
                addr_err <= 1'b1;
            end
            for (int i = 0; i < NUM_RD_PORTS; i++) begin
                if (rd_acc[i] && rd_cnt_q[i] != 32'hFFFF_FFFF) begin
                    rd_cnt_q[i] <= rd_cnt_q[i] + 32'd1;
                end
                // Data stages only load behind a valid token, so the output holds its last response.
                pipe_v[i][0] <= rd_acc[i];
                if (rd_acc[i]) begin
                    pipe_d[i][0] <= rd_cap[i];
                end
                for (int s = 1; s < RD_LATENCY; s++) begin
                    pipe_v[i][s] <= pipe_v[i][s-1];
                    if (pipe_v[i][s-1]) begin
                        pipe_d[i][s] <= pipe_d[i][s-1];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            rd_rsp_valid[i]                  = pipe_v[i][RD_LATENCY-1];
            rd_rsp_data[i*DATA_W +: DATA_W]  = pipe_d[i][RD_LATENCY-1];
            rd_cnt[i*32 +: 32]               = rd_cnt_q[i];
        end
    end

endmodule

// File: tb/tb_vpu_sram_port_model.sv
// Bench for vpu_sram_port_model: one instance without stalls for directed checks, one
// with LFSR stalls for streaming; a negedge monitor pops expected responses per channel.
module tb_vpu_sram_port_model;

    localparam int NP  = 3;
    localparam int AW  = 16;
    localparam int DW  = 256;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst0_n, rst1_n;
    always #5 clk = ~clk;

    logic [NP-1:0]    rd_req_valid0, rd_req_ready0, rd_rsp_valid0;
    logic [NP*AW-1:0] rd_req_addr0;
    logic [NP*DW-1:0] rd_rsp_data0;
    logic             wr_req_valid0, wr_req_ready0, wr_done0, addr_err0;
    logic [AW-1:0]    wr_req_addr0;
    logic [DW-1:0]    wr_req_data0;
    logic [NP*32-1:0] rd_cnt0;
    logic [31:0]      wr_cnt0;

    logic [NP-1:0]    rd_req_valid1, rd_req_ready1, rd_rsp_valid1;
    logic [NP*AW-1:0] rd_req_addr1;
    logic [NP*DW-1:0] rd_rsp_data1;
    logic             wr_req_valid1, wr_req_ready1, wr_done1, addr_err1;
    logic [AW-1:0]    wr_req_addr1;
    logic [DW-1:0]    wr_req_data1;
    logic [NP*32-1:0] rd_cnt1;
    logic [31:0]      wr_cnt1;

    logic          s_valid [NP];
    logic [AW-1:0] s_addr  [NP];
    assign rd_req_valid1 = {s_valid[2], s_valid[1], s_valid[0]};
    assign rd_req_addr1  = {s_addr[2], s_addr[1], s_addr[0]};

    vpu_sram_port_model #(.STALL_EN(0)) dut0 (
        .clk(clk), .rst_n(rst0_n),
        .rd_req_valid(rd_req_valid0), .rd_req_ready(rd_req_ready0), .rd_req_addr(rd_req_addr0),
        .rd_rsp_valid(rd_rsp_valid0), .rd_rsp_data(rd_rsp_data0),
        .wr_req_valid(wr_req_valid0), .wr_req_ready(wr_req_ready0), .wr_req_addr(wr_req_addr0),
        .wr_req_data(wr_req_data0), .wr_done(wr_done0),
        .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0), .addr_err(addr_err0)
    );

    vpu_sram_port_model #(.STALL_EN(1)) dut1 (
        .clk(clk), .rst_n(rst1_n),
        .rd_req_valid(rd_req_valid1), .rd_req_ready(rd_req_ready1), .rd_req_addr(rd_req_addr1),
        .rd_rsp_valid(rd_rsp_valid1), .rd_rsp_data(rd_rsp_data1),
        .wr_req_valid(wr_req_valid1), .wr_req_ready(wr_req_ready1), .wr_req_addr(wr_req_addr1),
        .wr_req_data(wr_req_data1), .wr_done(wr_done1),
        .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1), .addr_err(addr_err1)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Queues 0..2 belong to dut0 channels, 3..5 to dut1 channels.
    logic [DW-1:0] exp_data_q [6][$];
    int unsigned   exp_due_q  [6][$];
    int unsigned   wr_due_q   [$];
    int            checks = 0;
    int            fails  = 0;
    int            stall_seen = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic check_rsp(input int q, input logic v, input logic [DW-1:0] d);
        logic [DW-1:0] ed;
        int unsigned   due;
        if (v) begin
            checks++;
            if (exp_data_q[q].size() == 0) begin
                fails++;
                $display("FAIL rsp_unexpected q%0d: got %h at cycle %0d required no response", q, d, cyc);
            end else begin
                ed  = exp_data_q[q].pop_front();
                due = exp_due_q[q].pop_front();
                if (d !== ed || cyc != due) begin
                    fails++;
                    $display("FAIL rsp_q%0d: got %h at cycle %0d required %h at cycle %0d", q, d, cyc, ed, due);
                end
            end
        end else if (exp_due_q[q].size() != 0 && exp_due_q[q][0] < cyc) begin
            checks++;
            fails++;
            $display("FAIL rsp_missing q%0d: got none by cycle %0d required response at cycle %0d",
                     q, cyc, exp_due_q[q][0]);
            void'(exp_data_q[q].pop_front());
            void'(exp_due_q[q].pop_front());
        end
    endtask

    always @(negedge clk) begin
        for (int ch = 0; ch < NP; ch++) begin
            check_rsp(ch, rd_rsp_valid0[ch], rd_rsp_data0[ch*DW +: DW]);
            check_rsp(NP + ch, rd_rsp_valid1[ch], rd_rsp_data1[ch*DW +: DW]);
        end
        if (wr_done0) begin
            checks++;
            if (wr_due_q.size() == 0 || wr_due_q[0] != cyc) begin
                fails++;
                $display("FAIL wr_done_timing: got pulse at cycle %0d required %0d", cyc,
                         (wr_due_q.size() == 0) ? 0 : wr_due_q[0]);
            end
            if (wr_due_q.size() != 0) void'(wr_due_q.pop_front());
        end else if (wr_due_q.size() != 0 && wr_due_q[0] < cyc) begin
            checks++;
            fails++;
            $display("FAIL wr_done_missing: got none by cycle %0d required %0d", cyc, wr_due_q[0]);
            void'(wr_due_q.pop_front());
        end
        if (wr_done1) begin
            checks++;
            fails++;
            $display("FAIL wr_done1: got pulse at cycle %0d required none", cyc);
        end
        if ((s_valid[0] || s_valid[1] || s_valid[2]) && rd_req_ready1 != 3'b111) stall_seen++;
    end

    // Issues any mix of reads and one write to dut0 on the same edge.
    task automatic issue0(input logic [NP-1:0] rm, input logic [NP*AW-1:0] ra,
                          input logic [NP*DW-1:0] rdat, input logic wv,
                          input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        int n = 0;
        rd_req_valid0 = rm;
        rd_req_addr0  = ra;
        wr_req_valid0 = wv;
        wr_req_addr0  = wa;
        wr_req_data0  = wd;
        while (((rd_req_ready0 & rm) != rm || (wv && !wr_req_ready0)) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) begin
            checks++;
            fails++;
            $display("FAIL issue0_timeout: got ready %b required accept within 50 cycles", rd_req_ready0);
        end else begin
            for (int ch = 0; ch < NP; ch++) begin
                if (rm[ch]) begin
                    exp_data_q[ch].push_back(rdat[ch*DW +: DW]);
                    exp_due_q[ch].push_back(cyc + LAT);
                end
            end
            if (wv) wr_due_q.push_back(cyc + 1);
            @(posedge clk); #1;
        end
        rd_req_valid0 = '0;
        wr_req_valid0 = 1'b0;
    endtask

    task automatic rd0(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
        issue0(NP'(1 << ch), {NP{a}}, {NP{d}}, 1'b0, '0, '0);
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        issue0('0, '0, '0, 1'b1, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic stream1(input int ch);
        logic [AW-1:0] a;
        int n;
        for (int k = 0; k < 100; k++) begin
            a = AW'(ch * 300 + k);
            s_valid[ch] = 1'b1;
            s_addr[ch]  = a;
            n = 0;
            while (!rd_req_ready1[ch] && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (n == 200) begin
                checks++;
                fails++;
                $display("FAIL stream_timeout ch%0d: got no accept required accept within 200 cycles", ch);
                break;
            end
            exp_data_q[NP + ch].push_back({(DW / AW){a}});
            exp_due_q[NP + ch].push_back(cyc + LAT);
            @(posedge clk); #1;
        end
        s_valid[ch] = 1'b0;
    endtask

    localparam logic [DW-1:0] PAT12 = {16{16'h0012}};
    localparam logic [DW-1:0] PAT7  = {16{16'h0007}};
    localparam logic [DW-1:0] PAT5  = {16{16'h0005}};
    localparam logic [DW-1:0] PAT3  = {16{16'h0003}};
    localparam logic [DW-1:0] DB    = {8{32'hDEADBEEF}};
    localparam logic [DW-1:0] D0    = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [DW-1:0] ONES  = {DW{1'b1}};

    initial begin
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        rd_req_valid0 = '0; rd_req_addr0 = '0;
        wr_req_valid0 = 1'b0; wr_req_addr0 = '0; wr_req_data0 = '0;
        wr_req_valid1 = 1'b0; wr_req_addr1 = '0; wr_req_data1 = '0;
        for (int ch = 0; ch < NP; ch++) begin
            s_valid[ch] = 1'b0;
            s_addr[ch]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        @(negedge clk);
        chk("rst_rd_ready", rd_req_ready0, 3'b111);
        chk("rst_wr_ready", wr_req_ready0, 1'b1);
        chk("rst_rsp_valid", rd_rsp_valid0, 3'b000);
        chk("rst_rsp_data_zero", |rd_rsp_data0, 1'b0);
        chk("rst_rd_cnt", rd_cnt0, '0);
        chk("rst_wr_cnt", wr_cnt0, '0);
        chk("rst_addr_err", addr_err0, 1'b0);

        rd0(0, 16'h0012, PAT12);
        chk("rd_cnt0_first", rd_cnt0[31:0], 32'd1);
        idle(4);
        chk("rsp_data_held", rd_rsp_data0[DW-1:0], PAT12);

        wr0(16'd5, DB);
        chk("wr_cnt_first", wr_cnt0, 32'd1);
        idle(2);
        rd0(1, 16'd5, DB);
        idle(4);

        issue0(3'b011, {16'd0, 16'd5, 16'd5}, {3{DB}}, 1'b0, '0, '0);
        idle(4);

        issue0(3'b100, {3{16'd7}}, {3{PAT7}}, 1'b1, 16'd7, ONES);
        idle(3);
        rd0(2, 16'd7, ONES);
        idle(4);

        chk("addr_err_before", addr_err0, 1'b0);
        wr0(16'd0, D0);
        idle(2);
        rd0(0, 16'd1024, D0);
        idle(4);
        chk("addr_err_set", addr_err0, 1'b1);
        chk("rd_cnt0_ch0", rd_cnt0[31:0], 32'd3);
        chk("rd_cnt0_ch1", rd_cnt0[63:32], 32'd2);
        chk("rd_cnt0_ch2", rd_cnt0[95:64], 32'd2);
        chk("wr_cnt_total", wr_cnt0, 32'd3);

        // Reset lands one cycle after the accept, before the response is due.
        rd0(1, 16'd3, PAT3);
        rst0_n = 1'b0;
        exp_data_q[1].delete();
        exp_due_q[1].delete();
        idle(2);
        rst0_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", rd_rsp_valid0, 3'b000);
        end
        chk("addr_err_cleared", addr_err0, 1'b0);
        chk("rd_cnt_cleared", rd_cnt0, '0);
        chk("wr_cnt_cleared", wr_cnt0, '0);
        #1;
        rd0(1, 16'd5, PAT5);
        idle(4);

        fork
            stream1(0);
            stream1(1);
            stream1(2);
        join
        for (int i = 0; i < 20; i++) begin
            if (exp_due_q[3].size() == 0 && exp_due_q[4].size() == 0 && exp_due_q[5].size() == 0) break;
            idle(1);
        end
        idle(2);
        chk("stream_cnt_ch0", rd_cnt1[31:0], 32'd100);
        chk("stream_cnt_ch1", rd_cnt1[63:32], 32'd100);
        chk("stream_cnt_ch2", rd_cnt1[95:64], 32'd100);
        chk("stall_observed", stall_seen > 0, 1'b1);
        for (int q = 0; q < 6; q++) begin
            chk("queue_drained", exp_due_q[q].size(), 0);
        end
        chk("wr_queue_drained", wr_due_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test required finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
